// File: rtl/mult_mat_pkg.sv
// Shared widths, frame length and loader state encoding for the mult_mat front end.
// CARGADOR_PARIDAD_EN adds a trailing even-parity bit to every frame.
package mult_mat_pkg;
  localparam int ANCHO_A = 6;
  localparam int ANCHO_B = 9;
  localparam int ANCHO_R = 6;
`ifdef CARGADOR_PARIDAD_EN
  localparam int LARGO_TRAMA = 16;
`else
  localparam int LARGO_TRAMA = 15;
`endif

  typedef enum logic [2:0] {
    LOAD_A  = 3'd0,
    LOAD_B  = 3'd1,
    LOAD_P  = 3'd2,
    ISSUE   = 3'd3,
    CAPTURE = 3'd4,
    DONE    = 3'd5
  } estado_t;
endpackage

// File: rtl/mult_mat.sv
// GF(2) 2x3 * 3x3 matrix multiplier; result register advances while clk_enable is high.
module mult_mat
  import mult_mat_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               clk_enable,
  input  logic [ANCHO_A-1:0] matriz_A,
  input  logic [ANCHO_B-1:0] matriz_B,
  output logic [ANCHO_R-1:0] matriz_resultado
);
  logic [ANCHO_R-1:0] producto;

  always_comb begin
    producto = '0;
    for (int i = 0; i < 2; i++)
      for (int j = 0; j < 3; j++)
        for (int k = 0; k < 3; k++)
          producto[3*i+j] = producto[3*i+j] ^ (matriz_A[3*i+k] & matriz_B[3*k+j]);
  end

  always_ff @(posedge clk) begin
    if (reset) matriz_resultado <= '0;
    else if (clk_enable) matriz_resultado <= producto;
  end
endmodule

// File: rtl/cargador_mult_mat.sv
// Bit-serial loader for mult_mat: shifts in A then B, strobes clk_enable, returns the result.
// CARGADOR_PARIDAD_EN adds a LOAD_P state and the err_paridad output.
module cargador_mult_mat
  import mult_mat_pkg::*;
#(
  parameter int MULT_LAT = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               bit_in,
  input  logic               bit_valid,
  output logic               bit_ready,
  output logic [ANCHO_A-1:0] matriz_A,
  output logic [ANCHO_B-1:0] matriz_B,
  output logic               clk_enable,
  input  logic [ANCHO_R-1:0] matriz_resultado,
  output logic [ANCHO_R-1:0] res_out,
  output logic               res_valid,
  input  logic               res_ready
`ifdef CARGADOR_PARIDAD_EN
  ,
  output logic               err_paridad
`endif
);
  localparam logic [3:0] LAT_INI = 4'(MULT_LAT - 1);

  estado_t    estado_q, estado_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] lat_q, lat_d;
  logic       acepta;
`ifdef CARGADOR_PARIDAD_EN
  logic       paridad_ok;
  assign paridad_ok = (bit_in == ((^matriz_A) ^ (^matriz_B)));
`endif

  always_comb begin
    estado_d  = estado_q;
    cnt_d     = cnt_q;
    lat_d     = lat_q;
    bit_ready = (estado_q == LOAD_A) || (estado_q == LOAD_B) || (estado_q == LOAD_P);
    acepta    = bit_valid && bit_ready;
    case (estado_q)
      LOAD_A:
        if (acepta) begin
          if (cnt_q == 4'(ANCHO_A - 1)) begin
            cnt_d    = '0;
            estado_d = LOAD_B;
          end else cnt_d = cnt_q + 4'd1;
        end
      LOAD_B:
        if (acepta) begin
          if (cnt_q == 4'(ANCHO_B - 1)) begin
            cnt_d = '0;
`ifdef CARGADOR_PARIDAD_EN
            estado_d = LOAD_P;
`else
            estado_d = ISSUE;
            lat_d    = LAT_INI;
`endif
          end else cnt_d = cnt_q + 4'd1;
        end
`ifdef CARGADOR_PARIDAD_EN
      // A bad frame is dropped here; mult_mat never sees an enable for it.
      LOAD_P:
        if (acepta) begin
          if (paridad_ok) begin
            estado_d = ISSUE;
            lat_d    = LAT_INI;
          end else estado_d = LOAD_A;
        end
`endif
      ISSUE:
        if (lat_q == 4'd0) estado_d = CAPTURE;
        else lat_d = lat_q - 4'd1;
      CAPTURE: estado_d = DONE;
      DONE:    if (res_ready) estado_d = LOAD_A;
      default: estado_d = LOAD_A;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= LOAD_A;
      cnt_q      <= '0;
      lat_q      <= '0;
      matriz_A   <= '0;
      matriz_B   <= '0;
      res_out    <= '0;
      res_valid  <= 1'b0;
      clk_enable <= 1'b0;
`ifdef CARGADOR_PARIDAD_EN
      err_paridad <= 1'b0;
`endif
    end else begin
      estado_q <= estado_d;
      cnt_q    <= cnt_d;
      lat_q    <= lat_d;
      if (acepta && estado_q == LOAD_A) matriz_A <= {bit_in, matriz_A[ANCHO_A-1:1]};
      if (acepta && estado_q == LOAD_B) matriz_B <= {bit_in, matriz_B[ANCHO_B-1:1]};
      if (estado_q == CAPTURE) res_out <= matriz_resultado;
      // Registered from the next state so the strobes line up with the state itself.
      clk_enable <= (estado_d == ISSUE);
      res_valid  <= (estado_d == DONE);
`ifdef CARGADOR_PARIDAD_EN
      if (acepta && estado_q == LOAD_P) err_paridad <= ~paridad_ok;
`endif
    end
  end
endmodule
